// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types for the two-requester DMA bus arbiter: FSM states, requester IDs and
// the round-robin candidate selection rule.
package dma_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRequest,
        StGranted,
        StActive,
        StRelease
    } arb_state_e;

    typedef logic req_id_t;

    localparam req_id_t REQ_CAMERA = 1'b0;
    localparam req_id_t REQ_SOBEL  = 1'b1;

    // On a tie the requester that did not own the bus last time wins.
    function automatic req_id_t pick_candidate(input logic    req0,
                                               input logic    req1,
                                               input req_id_t last_owner);
        if (req0 && req1) begin
            return ~last_owner;
        end else if (req0) begin
            return REQ_CAMERA;
        end else begin
            return REQ_SOBEL;
        end
    endfunction

endpackage

// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between the camera grabber (req0)
// and the sobel writer (req1); only the owner's burst reaches the bus and only it sees status.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int unsigned GRANT_TIMEOUT = 16,
    parameter int unsigned TIMER_WIDTH   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_req0_request,
    output logic        o_req0_grant,
    input  logic        i_req0_begin_trans,
    input  logic        i_req0_end_trans,
    input  logic [31:0] i_req0_address_data,
    input  logic [3:0]  i_req0_byte_enables,
    input  logic        i_req0_data_valid,
    input  logic [7:0]  i_req0_burst_size,
    output logic        o_req0_busy,
    output logic        o_req0_error,

    input  logic        i_req1_request,
    output logic        o_req1_grant,
    input  logic        i_req1_begin_trans,
    input  logic        i_req1_end_trans,
    input  logic [31:0] i_req1_address_data,
    input  logic [3:0]  i_req1_byte_enables,
    input  logic        i_req1_data_valid,
    input  logic [7:0]  i_req1_burst_size,
    output logic        o_req1_busy,
    output logic        o_req1_error,

    output logic        o_bus_request,
    input  logic        i_bus_grant,
    output logic        o_bus_begin_trans,
    output logic        o_bus_end_trans,
    output logic [31:0] o_bus_address_data,
    output logic [3:0]  o_bus_byte_enables,
    output logic        o_bus_data_valid,
    output logic [7:0]  o_bus_burst_size,
    input  logic        i_bus_busy,
    input  logic        i_bus_error,

    output logic        o_timeout_flag
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(GRANT_TIMEOUT - 1);

    arb_state_e             r_state;
    req_id_t                r_last_owner;
    req_id_t                r_candidate;
    req_id_t                r_owner;
    logic                   r_bus_request;
    logic                   r_grant0;
    logic                   r_grant1;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_timeout_flag;

    logic w_owned;
    logic w_own0;
    logic w_own1;
    logic w_cand_request;
    logic w_owner_begin;
    logic w_owner_end;

    // The owner exists only while GRANTED or ACTIVE; r_owner is stale elsewhere.
    assign w_owned        = (r_state == StGranted) || (r_state == StActive);
    assign w_own0         = w_owned && (r_owner == REQ_CAMERA);
    assign w_own1         = w_owned && (r_owner == REQ_SOBEL);
    assign w_cand_request = (r_candidate == REQ_SOBEL) ? i_req1_request : i_req0_request;
    assign w_owner_begin  = (r_owner == REQ_SOBEL) ? i_req1_begin_trans : i_req0_begin_trans;
    assign w_owner_end    = (r_owner == REQ_SOBEL) ? i_req1_end_trans : i_req0_end_trans;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= StIdle;
            r_last_owner   <= REQ_SOBEL;
            r_candidate    <= REQ_CAMERA;
            r_owner        <= REQ_CAMERA;
            r_bus_request  <= 1'b0;
            r_grant0       <= 1'b0;
            r_grant1       <= 1'b0;
            r_timer        <= '0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req0_request || i_req1_request) begin
                        r_candidate   <= pick_candidate(i_req0_request, i_req1_request,
                                                        r_last_owner);
                        r_bus_request <= 1'b1;
                        r_state       <= StRequest;
                    end
                end
                StRequest: begin
                    // A withdrawn candidate wins over a same-cycle upstream grant.
                    if (!w_cand_request) begin
                        r_bus_request <= 1'b0;
                        r_state       <= StIdle;
                    end else if (i_bus_grant) begin
                        r_owner  <= r_candidate;
                        r_grant0 <= (r_candidate == REQ_CAMERA);
                        r_grant1 <= (r_candidate == REQ_SOBEL);
                        r_timer  <= '0;
                        r_state  <= StGranted;
                    end
                end
                StGranted: begin
                    if (w_owner_begin) begin
                        if (w_owner_end) begin
                            r_bus_request <= 1'b0;
                            r_last_owner  <= r_owner;
                            r_state       <= StRelease;
                        end else begin
                            r_state <= StActive;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_timeout_flag <= 1'b1;
                        r_bus_request  <= 1'b0;
                        r_last_owner   <= r_owner;
                        r_state        <= StIdle;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StActive: begin
                    if (w_owner_end) begin
                        r_bus_request <= 1'b0;
                        r_last_owner  <= r_owner;
                        r_state       <= StRelease;
                    end
                end
                StRelease: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Combinational path so the owner's burst timing reaches the bus unchanged.
    always_comb begin
        o_bus_begin_trans  = 1'b0;
        o_bus_end_trans    = 1'b0;
        o_bus_address_data = '0;
        o_bus_byte_enables = '0;
        o_bus_data_valid   = 1'b0;
        o_bus_burst_size   = '0;
        if (w_own0) begin
            o_bus_begin_trans  = i_req0_begin_trans;
            o_bus_end_trans    = i_req0_end_trans;
            o_bus_address_data = i_req0_address_data;
            o_bus_byte_enables = i_req0_byte_enables;
            o_bus_data_valid   = i_req0_data_valid;
            o_bus_burst_size   = i_req0_burst_size;
        end else if (w_own1) begin
            o_bus_begin_trans  = i_req1_begin_trans;
            o_bus_end_trans    = i_req1_end_trans;
            o_bus_address_data = i_req1_address_data;
            o_bus_byte_enables = i_req1_byte_enables;
            o_bus_data_valid   = i_req1_data_valid;
            o_bus_burst_size   = i_req1_burst_size;
        end
    end

    assign o_req0_busy    = w_own0 & i_bus_busy;
    assign o_req0_error   = w_own0 & i_bus_error;
    assign o_req1_busy    = w_own1 & i_bus_busy;
    assign o_req1_error   = w_own1 & i_bus_error;
    assign o_req0_grant   = r_grant0;
    assign o_req1_grant   = r_grant1;
    assign o_bus_request  = r_bus_request;
    assign o_timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomised scoreboard bench for dma_bus_arbiter: grant order and bus beats are predicted
// from the round-robin rules and checked by an independent negedge monitor.
module tb_dma_bus_arbiter;

    typedef struct packed {
        logic [31:0] ad;
        logic [3:0]  be;
        logic [7:0]  bs;
        logic        b;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_request [2];
    logic        req_begin   [2];
    logic        req_end     [2];
    logic [31:0] req_ad      [2];
    logic [3:0]  req_be      [2];
    logic        req_dv      [2];
    logic [7:0]  req_bs      [2];
    logic        grant       [2];
    logic        busy        [2];
    logic        error       [2];
    logic        bus_grant;
    logic        bus_busy;
    logic        bus_error;
    logic        o_bus_request;
    logic        o_bus_begin_trans;
    logic        o_bus_end_trans;
    logic [31:0] o_bus_address_data;
    logic [3:0]  o_bus_byte_enables;
    logic        o_bus_data_valid;
    logic [7:0]  o_bus_burst_size;
    logic        o_timeout_flag;

    int    n_checks = 0;
    int    n_errors = 0;
    int    model_last = 1;
    int    q_grant [$];
    beat_t q_beat [$];
    int    mon_id;
    beat_t mon_beat;

    always #5 clk = ~clk;

    dma_bus_arbiter dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_req0_request      (req_request[0]),
        .o_req0_grant        (grant[0]),
        .i_req0_begin_trans  (req_begin[0]),
        .i_req0_end_trans    (req_end[0]),
        .i_req0_address_data (req_ad[0]),
        .i_req0_byte_enables (req_be[0]),
        .i_req0_data_valid   (req_dv[0]),
        .i_req0_burst_size   (req_bs[0]),
        .o_req0_busy         (busy[0]),
        .o_req0_error        (error[0]),
        .i_req1_request      (req_request[1]),
        .o_req1_grant        (grant[1]),
        .i_req1_begin_trans  (req_begin[1]),
        .i_req1_end_trans    (req_end[1]),
        .i_req1_address_data (req_ad[1]),
        .i_req1_byte_enables (req_be[1]),
        .i_req1_data_valid   (req_dv[1]),
        .i_req1_burst_size   (req_bs[1]),
        .o_req1_busy         (busy[1]),
        .o_req1_error        (error[1]),
        .o_bus_request       (o_bus_request),
        .i_bus_grant         (bus_grant),
        .o_bus_begin_trans   (o_bus_begin_trans),
        .o_bus_end_trans     (o_bus_end_trans),
        .o_bus_address_data  (o_bus_address_data),
        .o_bus_byte_enables  (o_bus_byte_enables),
        .o_bus_data_valid    (o_bus_data_valid),
        .o_bus_burst_size    (o_bus_burst_size),
        .i_bus_busy          (bus_busy),
        .i_bus_error         (bus_error),
        .o_timeout_flag      (o_timeout_flag)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side(input int n);
        req_begin[n] = 1'b0;
        req_end[n]   = 1'b0;
        req_ad[n]    = '0;
        req_be[n]    = '0;
        req_dv[n]    = 1'b0;
        req_bs[n]    = '0;
    endtask

    task automatic clear_all_but_requests();
        clear_side(0);
        clear_side(1);
        bus_grant = 1'b0;
        bus_busy  = 1'b0;
        bus_error = 1'b0;
    endtask

    // Garbage on a non-owner's bus-side inputs; the arbiter must ignore it.
    task automatic noise(input int n);
        req_begin[n] = 1'($urandom);
        req_end[n]   = 1'($urandom);
        req_ad[n]    = $urandom;
        req_be[n]    = 4'($urandom);
        req_dv[n]    = 1'($urandom);
        req_bs[n]    = 8'($urandom);
    endtask

    task automatic drive_beat(input int n, input bit first, input bit last, input int beats,
                              input bit push);
        beat_t bt;
        req_begin[n] = first;
        req_end[n]   = last;
        req_ad[n]    = $urandom;
        req_be[n]    = 4'($urandom);
        req_dv[n]    = 1'b1;
        req_bs[n]    = 8'(beats - 1);
        bt = '{ad: req_ad[n], be: req_be[n], bs: req_bs[n], b: first, e: last};
        if (push) q_beat.push_back(bt);
    endtask

    task automatic apply_reset();
        req_request[0] = 1'b0;
        req_request[1] = 1'b0;
        clear_all_but_requests();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_last = 1;
        tick();
    endtask

    // One owner transaction; caller has already raised req_request[id].
    task automatic run_txn(input int id, input int gdelay, input int beats, input int begin_wait,
                           input int err_beat, input bit exact);
        int other = 1 - id;
        int k = 0;
        bit pulse_checked = 1'b0;
        if (exact) begin
            tick();
            check("bus_request_latency", 64'(o_bus_request), 64'(1));
        end else begin
            while (!o_bus_request && k < 20) begin
                tick();
                k++;
            end
            check("bus_request_wait", 64'(o_bus_request), 64'(1));
        end
        repeat (gdelay) begin
            tick();
            check("no_early_grant", 64'(grant[id]), 64'(0));
        end
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check("grant_pulse", 64'(grant[id]), 64'(1));
        check("grant_exclusive", 64'(grant[other]), 64'(0));
        req_request[id] = 1'b0;
        for (int w = 0; w < begin_wait; w++) begin
            noise(other);
            tick();
            check("bus_quiet_before_begin", 64'(o_bus_data_valid), 64'(0));
            if (!pulse_checked) begin
                check("grant_one_cycle", 64'(grant[id]), 64'(0));
                pulse_checked = 1'b1;
            end
        end
        for (int b = 0; b < beats; b++) begin
            noise(other);
            drive_beat(id, b == 0, b == beats - 1, beats, 1'b1);
            bus_busy  = 1'($urandom);
            bus_error = (b == err_beat);
            #1;
            check("busy_owner", 64'(busy[id]), 64'(bus_busy));
            check("busy_other", 64'(busy[other]), 64'(0));
            check("error_other", 64'(error[other]), 64'(0));
            if (b == err_beat) check("error_owner", 64'(error[id]), 64'(1));
            if (err_beat >= 0 && b > err_beat)
                check("hold_after_error", 64'(o_bus_request), 64'(1));
            tick();
            if (!pulse_checked) begin
                check("grant_one_cycle", 64'(grant[id]), 64'(0));
                pulse_checked = 1'b1;
            end
        end
        clear_all_but_requests();
        #1;
        check("release_bus_request", 64'(o_bus_request), 64'(0));
        check("release_bus_quiet", 64'({o_bus_data_valid, o_bus_begin_trans, o_bus_end_trans}),
              64'(0));
        model_last = id;
    endtask

    task automatic random_txn(input int id, input bit exact);
        int beats = int'($urandom_range(1, 16));
        int err   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, beats - 1)) : -1;
        run_txn(id, int'($urandom_range(0, 4)), beats, int'($urandom_range(0, 3)), err, exact);
    endtask

    // pattern 0/1: that requester alone; pattern 2: both at once.
    task automatic scenario(input int pattern);
        int first;
        int second;
        if (pattern == 2) begin
            first  = 1 - model_last;
            second = model_last;
            q_grant.push_back(first);
            q_grant.push_back(second);
            req_request[0] = 1'b1;
            req_request[1] = 1'b1;
            random_txn(first, 1'b1);
            random_txn(second, 1'b0);
        end else begin
            q_grant.push_back(pattern);
            req_request[pattern] = 1'b1;
            random_txn(pattern, 1'b1);
        end
        tick();
    endtask

    always @(negedge clk) begin
        if (grant[0] || grant[1]) begin
            if (grant[0] && grant[1]) begin
                n_checks++;
                n_errors++;
                $display("FAIL grant_both: got 2 grants expected 1 at %0t", $time);
            end else if (q_grant.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_grant: got grant to %0d expected none at %0t",
                         grant[1] ? 1 : 0, $time);
            end else begin
                mon_id = q_grant.pop_front();
                check("grant_order", 64'(grant[1] ? 1 : 0), 64'(mon_id));
            end
        end
        if (o_bus_data_valid) begin
            if (q_beat.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got %0h expected none at %0t",
                         o_bus_address_data, $time);
            end else begin
                mon_beat = q_beat.pop_front();
                check("bus_beat", 64'({o_bus_address_data, o_bus_byte_enables, o_bus_burst_size,
                                       o_bus_begin_trans, o_bus_end_trans}), 64'(mon_beat));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_request[0] = 1'b0;
        req_request[1] = 1'b0;
        clear_all_but_requests();
        rst_n = 1'b0;
        #12;
        check("reset_bus_request", 64'(o_bus_request), 64'(0));
        check("reset_grants", 64'({grant[0], grant[1]}), 64'(0));
        check("reset_timeout", 64'(o_timeout_flag), 64'(0));
        check("reset_bus_out", 64'({o_bus_data_valid, o_bus_address_data}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Sobel alone, grant after 3 cycles, 16-beat burst.
        q_grant.push_back(1);
        req_request[1] = 1'b1;
        run_txn(1, 3, 16, 0, -1, 1'b1);
        tick();

        // Strict alternation starting with camera after reset.
        apply_reset();
        scenario(2);
        scenario(0);
        scenario(2);

        // Camera granted but never begins: revoked after 16 cycles, sobel next.
        q_grant.push_back(0);
        q_grant.push_back(1);
        req_request[0] = 1'b1;
        tick();
        check("to_bus_request", 64'(o_bus_request), 64'(1));
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        check("to_grant0", 64'(grant[0]), 64'(1));
        req_request[0] = 1'b0;
        req_request[1] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            noise(1);
            tick();
            check("to_nonowner_ignored", 64'(o_bus_data_valid), 64'(0));
        end
        check("to_flag_early", 64'(o_timeout_flag), 64'(0));
        check("to_still_held", 64'(o_bus_request), 64'(1));
        tick();
        clear_all_but_requests();
        check("to_flag_set", 64'(o_timeout_flag), 64'(1));
        check("to_bus_dropped", 64'(o_bus_request), 64'(0));
        run_txn(1, 1, 4, 0, -1, 1'b0);
        tick();

        // Bus error mid-burst on sobel.
        q_grant.push_back(1);
        req_request[1] = 1'b1;
        run_txn(1, 1, 8, 1, 3, 1'b1);
        tick();

        // Camera withdraws while waiting for the upstream grant.
        req_request[0] = 1'b1;
        tick();
        check("wd_bus_request", 64'(o_bus_request), 64'(1));
        req_request[0] = 1'b0;
        tick();
        check("wd_bus_dropped", 64'(o_bus_request), 64'(0));
        bus_grant = 1'b1;
        repeat (3) begin
            tick();
            check("wd_no_grant", 64'({grant[0], grant[1], o_bus_request}), 64'(0));
        end
        bus_grant = 1'b0;

        // Reset while sobel is mid-burst.
        q_grant.push_back(1);
        req_request[1] = 1'b1;
        tick();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        req_request[1] = 1'b0;
        drive_beat(1, 1'b1, 1'b0, 8, 1'b1);
        tick();
        drive_beat(1, 1'b0, 1'b0, 8, 1'b0);
        #1;
        check("mid_bus_valid", 64'(o_bus_data_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_bus_out", 64'({o_bus_data_valid, o_bus_begin_trans, o_bus_end_trans,
                                  o_bus_address_data}), 64'(0));
        check("rst_bus_request", 64'(o_bus_request), 64'(0));
        check("rst_timeout_cleared", 64'(o_timeout_flag), 64'(0));
        clear_all_but_requests();
        tick();
        rst_n = 1'b1;
        model_last = 1;
        tick();
        check("post_rst_idle", 64'({o_bus_request, o_bus_data_valid}), 64'(0));

        for (int t = 0; t < 30; t++) scenario(int'($urandom_range(0, 2)));

        repeat (3) tick();
        check("grants_drained", 64'(q_grant.size()), 64'(0));
        check("beats_drained", 64'(q_beat.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
